// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the execute stage.
// Shift-add multiply, restoring divide, and a final sign-fix cycle that writes hi/lo.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d, div_op_q, div_op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, div_zero_q, div_zero_d;

  logic               op_hit, req, accept, is_signed, rs_neg, rt_neg, last_iter;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;

  always_comb begin
    op_hit = 1'b0;
    case (func)
      6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27: op_hit = 1'b1;
      default: op_hit = 1'b0;
    endcase
  end

  assign req       = valid && (ALUOp == 2'd2) && op_hit;
  assign busy      = (state_q != S_IDLE);
  assign accept    = req && !busy;
  assign stall     = req && busy;
  assign rd_data   = (func == 6'd16) ? hi_q : lo_q;
  assign is_signed = ~func[0];
  assign rs_neg    = is_signed & rs_val[WIDTH-1];
  assign rt_neg    = is_signed & rt_val[WIDTH-1];
  assign last_iter = (cnt_q == CW'(WIDTH-1));

  // Multiply: add into the upper half, then shift the whole accumulator right.
  assign mul_add  = b_q[0] ? a_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  // Divide: dividend MSBs shift into the remainder; the top bit of the difference is the borrow.
  assign div_diff = {rem_q, a_q[WIDTH-1]} - {2'b00, b_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    rs_raw_d   = rs_raw_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    dz_d       = dz_q;
    div_op_d   = div_op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (func)
            6'd17: hi_d = rs_val;
            6'd19: lo_d = rs_val;
            6'd24, 6'd25, 6'd26, 6'd27: begin
              a_d      = rs_neg ? -rs_val : rs_val;
              b_d      = rt_neg ? -rt_val : rt_val;
              sa_d     = rs_neg;
              sb_d     = rt_neg;
              rs_raw_d = rs_val;
              div_op_d = func[1];
              dz_d     = func[1] && (rt_val == '0);
              cnt_d    = '0;
              acc_d    = '0;
              rem_d    = '0;
              state_d  = func[1] ? S_DIV : S_MUL;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) state_d = S_FIX;
      end
      S_DIV: begin
        rem_d = div_diff[WIDTH+1] ? {rem_q[WIDTH-1:0], a_q[WIDTH-1]} : div_diff[WIDTH:0];
        a_d   = {a_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!div_op_q) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? -acc_q : acc_q;
        end else if (dz_q) begin
          hi_d       = rs_raw_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -a_q : a_q;
          hi_d = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      rs_raw_q   <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      div_op_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      rs_raw_q   <= rs_raw_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_q       <= dz_d;
      div_op_q   <= div_op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
